speck_round_engine: RTL and testbench

SPECK_ROUND_ENGINE -- requirements
Module: speck_round_engine

---
 rtl/speck_pkg.sv | 27 ++
 rtl/speck_round_engine_if.sv | 34 +++
 rtl/speck_round_comb.sv | 41 ++++
 rtl/speck_round_engine.sv | 105 ++++++++++
 tb/tb_speck_round_engine.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/speck_pkg.sv
// speck_pkg -- shared definitions for the SPECK round engine.
//   state_t          : FSM state encoding (IDLE / RUN / DONE)
//   speck_alpha()    : right-rotate amount applied to x for a given word size
//   speck_beta()     : left-rotate amount applied to y for a given word size
//   legal_word_size(): true for the word sizes the SPECK family defines
package speck_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Speck32 (n = 16) uses the smaller rotation pair; every wider variant uses 8/3.
  function automatic int unsigned speck_alpha(input int unsigned n);
    return (n == 16) ? 7 : 8;
  endfunction

  function automatic int unsigned speck_beta(input int unsigned n);
    return (n == 16) ? 2 : 3;
  endfunction

  function automatic bit legal_word_size(input int unsigned n);
    return (n == 16) || (n == 24) || (n == 32) || (n == 48) || (n == 64);
  endfunction

endpackage

// File: rtl/speck_round_engine_if.sv
// speck_round_engine_if -- block, round-key and result channels of the engine.
//   in_valid/in_ready/in_mode/in_block : block input channel (x in upper half, y in lower)
//   key_req/key_idx/key_valid/round_key: round-key fetch channel
//   out_valid/out_ready/out_block      : result channel
// Handshake rule for all three channels: a transfer happens on a rising clk
// edge where both the offering side (valid / key_req) and the accepting side
// (ready / key_valid) are high; the offering side holds its payload stable
// until that edge, and the engine never queues an offer it did not accept.
// master = the environment around the engine, slave = the engine itself.
interface speck_round_engine_if #(
  parameter int WORD_SIZE = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_mode;
  logic [2*WORD_SIZE-1:0] in_block;
  logic                   key_req;
  logic [5:0]             key_idx;
  logic                   key_valid;
  logic [WORD_SIZE-1:0]   round_key;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WORD_SIZE-1:0] out_block;

  modport master (
    output in_valid, in_mode, in_block, key_valid, round_key, out_ready,
    input  in_ready, key_req, key_idx, out_valid, out_block
  );

  modport slave (
    input  in_valid, in_mode, in_block, key_valid, round_key, out_ready,
    output in_ready, key_req, key_idx, out_valid, out_block
  );
endinterface

// File: rtl/speck_round_comb.sv
// speck_round_comb -- one combinational SPECK round, encrypt or decrypt.
//   x, y     : current state words
//   k        : round key for this round
//   mode     : 0 encrypt, 1 decrypt (inverse round)
//   x_next, y_next : state words after the round
module speck_round_comb
  import speck_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [WORD_SIZE-1:0] x,
  input  logic [WORD_SIZE-1:0] y,
  input  logic [WORD_SIZE-1:0] k,
  input  logic                 mode,
  output logic [WORD_SIZE-1:0] x_next,
  output logic [WORD_SIZE-1:0] y_next
);
  localparam int ALPHA = int'(speck_alpha(WORD_SIZE));
  localparam int BETA  = int'(speck_beta(WORD_SIZE));

  // Rotate amounts are elaboration constants, so these are pure wiring.
  function automatic logic [WORD_SIZE-1:0] ror(input logic [WORD_SIZE-1:0] v, input int s);
    return (v >> s) | (v << (WORD_SIZE - s));
  endfunction

  function automatic logic [WORD_SIZE-1:0] rol(input logic [WORD_SIZE-1:0] v, input int s);
    return (v << s) | (v >> (WORD_SIZE - s));
  endfunction

  logic [WORD_SIZE-1:0] x_enc, y_enc, x_dec, y_dec;

  always_comb begin
    x_enc = (ror(x, ALPHA) + y) ^ k;
    y_enc = rol(y, BETA) ^ x_enc;
    // Decrypt undoes the encrypt round: recover y first, then x.
    y_dec = ror(x ^ y, BETA);
    x_dec = rol((x ^ k) - y_dec, ALPHA);
    x_next = mode ? x_dec : x_enc;
    y_next = mode ? y_dec : y_enc;
  end
endmodule

// File: rtl/speck_round_engine.sv
// speck_round_engine -- iterative SPECK block cipher core (one round per key).
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : block / round-key / result channels (speck_round_engine_if.slave)
//   busy       : high whenever the FSM is not IDLE
//   dbg_state  : raw FSM state for observation
// Round keys come from outside, one per cycle on request; the engine walks
// them upwards for encryption and downwards for decryption.
module speck_round_engine
  import speck_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int ROUNDS    = 27
) (
  input  logic                 clk,
  input  logic                 rst_n,
  speck_round_engine_if.slave  bus,
  output logic                 busy,
  output state_t               dbg_state
);
  if (!legal_word_size(WORD_SIZE)) begin : g_bad_word_size
    $error("speck_round_engine: WORD_SIZE %0d is not a SPECK word size", WORD_SIZE);
  end
  if (ROUNDS < 1 || ROUNDS > 63) begin : g_bad_rounds
    $error("speck_round_engine: ROUNDS %0d outside 1..63", ROUNDS);
  end

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  state_t               state_q, state_d;
  logic [5:0]           r_q, r_d;
  logic [WORD_SIZE-1:0] x_q, x_d, y_q, y_d;
  logic                 mode_q, mode_d;
  logic [WORD_SIZE-1:0] x_rnd, y_rnd;

  // Single shared round datapath, fed from the state registers every cycle.
  speck_round_comb #(.WORD_SIZE(WORD_SIZE)) u_round (
    .x      (x_q),
    .y      (y_q),
    .k      (bus.round_key),
    .mode   (mode_q),
    .x_next (x_rnd),
    .y_next (y_rnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    r_d           = r_q;
    x_d           = x_q;
    y_d           = y_q;
    mode_d        = mode_q;
    bus.in_ready  = 1'b0;
    bus.key_req   = 1'b0;
    bus.key_idx   = '0;
    bus.out_valid = 1'b0;
    bus.out_block = '0;
    unique case (state_q)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          x_d     = bus.in_block[2*WORD_SIZE-1:WORD_SIZE];
          y_d     = bus.in_block[WORD_SIZE-1:0];
          mode_d  = bus.in_mode;
          r_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        bus.key_req = 1'b1;
        bus.key_idx = mode_q ? (LAST_ROUND - r_q) : r_q;
        // Without a key the round simply waits; nothing advances.
        if (bus.key_valid) begin
          x_d = x_rnd;
          y_d = y_rnd;
          r_d = r_q + 6'd1;
          if (r_q == LAST_ROUND) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        bus.out_block = {x_q, y_q};
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;
endmodule

// File: tb/tb_speck_round_engine.sv
module tb_speck_round_engine;
  import speck_pkg::*;

  localparam int N   = 32;
  localparam int R   = 27;
  localparam int N16 = 16;
  localparam int R16 = 22;

  localparam logic [63:0] PT64 = 64'h3b72_6574_7475_432d;
  localparam logic [63:0] CT64 = 64'h8c6f_a548_454e_028b;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  speck_round_engine_if #(.WORD_SIZE(N))   bus();
  speck_round_engine_if #(.WORD_SIZE(N16)) bus16();
  logic   busy, busy16;
  state_t dbg_state, dbg_state16;

  speck_round_engine #(.WORD_SIZE(N), .ROUNDS(R)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .dbg_state(dbg_state)
  );

  speck_round_engine #(.WORD_SIZE(N16), .ROUNDS(R16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16), .busy(busy16), .dbg_state(dbg_state16)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] msk(input int n);
    return (n == 32) ? 32'hffff_ffff : ((32'h1 << n) - 32'h1);
  endfunction

  function automatic logic [31:0] ror_n(input logic [31:0] v, input int s, input int n);
    return ((v >> s) | (v << (n - s))) & msk(n);
  endfunction

  function automatic logic [31:0] rol_n(input logic [31:0] v, input int s, input int n);
    return ror_n(v, n - s, n);
  endfunction

  // Round key i of the standard 4-word SPECK key schedule, computed from scratch.
  function automatic logic [31:0] key_at(input int n, input logic [31:0] k0, input logic [31:0] l0,
                                         input logic [31:0] l1, input logic [31:0] l2, input int idx);
    logic [31:0] k;
    logic [31:0] l[$];
    int a, b;
    a = (n == 16) ? 7 : 8;
    b = (n == 16) ? 2 : 3;
    k = k0;
    l = '{l0, l1, l2};
    for (int i = 0; i < idx; i++) begin
      l.push_back(((k + ror_n(l[i], a, n)) & msk(n)) ^ 32'(i));
      k = rol_n(k, b, n) ^ l[i + 3];
    end
    return k;
  endfunction

  logic [31:0] rk32[R];
  logic [15:0] rk16[R16];

  // Whole-block Speck64 cipher on the expanded key table.
  function automatic logic [63:0] model(input logic mode, input logic [63:0] blk);
    logic [31:0] x, y;
    x = blk[63:32];
    y = blk[31:0];
    if (!mode) begin
      for (int i = 0; i < R; i++) begin
        x = (ror_n(x, 8, 32) + y) ^ rk32[i];
        y = rol_n(y, 3, 32) ^ x;
      end
    end else begin
      for (int i = R - 1; i >= 0; i--) begin
        y = ror_n(x ^ y, 3, 32);
        x = rol_n((x ^ rk32[i]) - y, 8, 32);
      end
    end
    return {x, y};
  endfunction

  // ---------------- round-key responders ----------------
  int          key_duty = 100;
  logic [5:0]  idx_log[$];
  bit          stall_prev = 1'b0;
  logic [5:0]  held_idx = '0;

  initial begin
    bus.key_valid = 1'b0;
    bus.round_key = '0;
    forever begin
      @(negedge clk);
      if (bus.key_req) begin
        if (stall_prev) check("key_idx_hold", 64'(bus.key_idx), 64'(held_idx));
        if ($urandom_range(99) < key_duty) begin
          bus.key_valid = 1'b1;
          bus.round_key = (bus.key_idx < R) ? rk32[bus.key_idx] : 32'h0;
          idx_log.push_back(bus.key_idx);
          stall_prev = 1'b0;
        end else begin
          bus.key_valid = 1'b0;
          bus.round_key = $urandom;
          stall_prev = 1'b1;
          held_idx = bus.key_idx;
        end
      end else begin
        // Noise outside RUN must be ignored by the engine.
        bus.key_valid = 1'($urandom_range(1));
        bus.round_key = $urandom;
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    bus16.key_valid = 1'b0;
    bus16.round_key = '0;
    forever begin
      @(negedge clk);
      bus16.key_valid = bus16.key_req;
      bus16.round_key = (bus16.key_idx < R16) ? rk16[bus16.key_idx] : 16'h0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic start_block(input logic mode, input logic [63:0] blk);
    int cyc;
    idx_log.delete();
    cyc = 0;
    while (!bus.in_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_block = blk;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_mode  = 1'($urandom_range(1));
    bus.in_block = {$urandom, $urandom};
  endtask

  // Returns the number of edges from the accept edge to out_valid.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_wait", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        mode;
    logic [63:0] blk;
    logic [63:0] exp;
    int          duty;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          lat, bad;
    int          accepts[$];
    int          rises[$];
    bit          prev_ov, seen;
    logic [63:0] blk, exp;
    logic [5:0]  want;

    bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_block = '0; bus.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.in_mode = 1'b0; bus16.in_block = '0; bus16.out_ready = 1'b0;

    for (int i = 0; i < R; i++)
      rk32[i] = key_at(32, 32'h0302_0100, 32'h0b0a_0908, 32'h1312_1110, 32'h1b1a_1918, i);
    for (int i = 0; i < R16; i++)
      rk16[i] = 16'(key_at(16, 32'h0100, 32'h0908, 32'h1110, 32'h1918, i));

    vecs[0] = '{mode: 1'b0, blk: PT64, exp: CT64, duty: 100};
    vecs[1] = '{mode: 1'b1, blk: CT64, exp: PT64, duty: 30};
    for (int i = 2; i < 8; i++) begin
      vecs[i].mode = 1'(i % 2);
      vecs[i].blk  = {$urandom, $urandom};
      vecs[i].exp  = model(vecs[i].mode, vecs[i].blk);
      vecs[i].duty = (i < 5) ? 30 : 100;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_key_req",   64'(bus.key_req),   64'd0);
    check("rst_key_idx",   64'(bus.key_idx),   64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_block", bus.out_block,      64'd0);
    check("rst_busy",      64'(busy),          64'd0);
    check("rst_state",     64'(dbg_state),     64'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Speck32/64 published vector on the narrow engine
    bus16.in_valid = 1'b1; bus16.in_mode = 1'b0; bus16.in_block = 32'h6574_694c;
    @(negedge clk);
    bus16.in_valid = 1'b0;
    lat = 0;
    while (!bus16.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("spk16_latency", 64'(lat), 64'(R16));
    check("spk16_ct", 64'(bus16.out_block), 64'h0000_0000_a868_42f2);
    bus16.out_ready = 1'b1;
    @(negedge clk);
    bus16.out_ready = 1'b0;

    // Table-driven blocks with varying key availability
    for (int v = 0; v < 8; v++) begin
      key_duty = vecs[v].duty;
      start_block(vecs[v].mode, vecs[v].blk);
      wait_out(lat);
      check($sformatf("vec%0d_result", v), bus.out_block, vecs[v].exp);
      if (vecs[v].duty == 100) check($sformatf("vec%0d_latency", v), 64'(lat), 64'(R));
      check($sformatf("vec%0d_idx_count", v), 64'(idx_log.size()), 64'(R));
      bad = 0;
      for (int j = 0; j < idx_log.size(); j++) begin
        want = vecs[v].mode ? 6'(R - 1 - j) : 6'(j);
        if (idx_log[j] != want) bad++;
      end
      check($sformatf("vec%0d_idx_order_errors", v), 64'(bad), 64'd0);
      release_out();
    end

    // Result held under back-pressure; new offers ignored
    key_duty = 100;
    blk = {$urandom, $urandom};
    exp = model(1'b0, blk);
    start_block(1'b0, blk);
    wait_out(lat);
    bus.in_valid = 1'b1;
    bus.in_block = {$urandom, $urandom};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_out_block", bus.out_block, exp);
      check("bp_in_ready",  64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp_no_queued_busy", 64'(busy), 64'd0);
    check("bp_no_queued_ready", 64'(bus.in_ready), 64'd1);

    // Reset in the middle of a block
    start_block(1'b0, {$urandom, $urandom});
    lat = 0;
    while (idx_log.size() < 5 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("mid_rst_reached_round5", 64'(idx_log.size() >= 5), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("mid_rst_key_req",   64'(bus.key_req),   64'd0);
    check("mid_rst_key_idx",   64'(bus.key_idx),   64'd0);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_out_block", bus.out_block,      64'd0);
    check("mid_rst_busy",      64'(busy),          64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.out_valid || busy) seen = 1'b1;
    end
    check("mid_rst_no_output", 64'(seen), 64'd0);
    start_block(1'b0, PT64);
    wait_out(lat);
    check("after_rst_result", bus.out_block, CT64);
    check("after_rst_latency", 64'(lat), 64'(R));
    release_out();

    // Back-to-back throughput with keys and out_ready always available
    blk = {$urandom, $urandom};
    exp = model(1'b0, blk);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_mode   = 1'b0;
    bus.in_block  = blk;
    bus.in_valid  = 1'b1;
    prev_ov = 1'b0;
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      if (bus.in_ready && bus.in_valid) accepts.push_back(c + 1);
      @(negedge clk);
      if (bus.out_valid && !prev_ov) rises.push_back(c + 1);
      if (bus.out_valid && bus.out_block !== exp) bad++;
      prev_ov = bus.out_valid;
    end
    bus.in_valid = 1'b0;
    check("tp_accept_count_ge2", 64'(accepts.size() >= 2), 64'd1);
    check("tp_rise_count_ge2",   64'(rises.size() >= 2),   64'd1);
    if (accepts.size() >= 2 && rises.size() >= 2) begin
      check("tp_block_spacing", 64'(accepts[1] - accepts[0]), 64'(R + 2));
      check("tp_latency0",      64'(rises[0] - accepts[0]),   64'(R));
      check("tp_latency1",      64'(rises[1] - accepts[1]),   64'(R));
    end
    check("tp_result_errors", 64'(bad), 64'd0);
    lat = 0;
    while (busy && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("tp_drained", 64'(busy), 64'd0);
    bus.out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
